debounce_bank: RTL and testbench

Multi-channel, parametrised debouncer for board buttons and switches. Each channel synchronises an asynchronous input and filters it with a saturating integrating counter with hysteresis. Each channel provides a clean level or fixed-length pulse output, plus single-cycle press and release strobes. It sits between top-level pads and control logic (MAC test triggers, mode switches), replacing per-button instances with one bank.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 136 +++++++++++++
 rtl/debounce_bank.sv | 38 +++
 tb/tb_debounce_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: pulse FSM encoding and
// the integrator saturation limit.
package debounce_pkg;

  // Pulse-mode FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SIG  = 2'd1,
    ST_DEAS = 2'd2
  } pulse_state_t;

  // Saturation value of an integrator that is w bits wide.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, saturating integrator with
// hysteresis, edge strobes and an optional fixed-length pulse FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   CNT_WIDTH    = 10,
  parameter int   SYNC_STAGES  = 2,
  parameter int   PULSE_LENGTH = 0,
  parameter logic INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_lvl;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_eff;
  logic                   w_at_max;
  logic                   w_at_zero;

  // Synchroniser chain; resets to the idle pad level so eff starts at 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync <= {SYNC_STAGES{INVERT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
    end
  end

  assign w_eff     = r_sync[SYNC_STAGES-1] ^ INVERT;
  assign w_at_max  = (r_cnt == MAX);
  assign w_at_zero = (r_cnt == '0);

  // Saturating integrator: counts toward the current effective level, never wraps.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_eff && !w_at_max) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end else if (!w_eff && !w_at_zero) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  // Hysteresis level plus edge strobes, all registered on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_at_max & ~r_lvl;
      r_fall <= w_at_zero & r_lvl;
      if (w_at_max) begin
        r_lvl <= 1'b1;
      end else if (w_at_zero) begin
        r_lvl <= 1'b0;
      end
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;

  generate
    if (PULSE_LENGTH == 0) begin : g_level
      assign out = r_lvl ^ INVERT;
    end else begin : g_pulse
      localparam int            PW   = $clog2(PULSE_LENGTH + 1);
      localparam logic [PW-1:0] PLEN = PW'(PULSE_LENGTH);

      pulse_state_t  r_state;
      pulse_state_t  w_state_next;
      logic [PW-1:0] r_pcnt;
      logic [PW-1:0] w_pcnt_next;
      logic          w_pulse;

      // FSM state and pulse-length counter registers.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_state <= ST_WAIT;
          r_pcnt  <= '0;
        end else begin
          r_state <= w_state_next;
          r_pcnt  <= w_pcnt_next;
        end
      end

      // Next state: one pulse per full press, rearmed only after cnt hits 0.
      always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        case (r_state)
          ST_WAIT: begin
            if (w_at_max) begin
              w_state_next = ST_SIG;
              w_pcnt_next  = PW'(1);
            end
          end
          ST_SIG: begin
            if (r_pcnt == PLEN) begin
              w_state_next = ST_DEAS;
            end else begin
              w_pcnt_next = r_pcnt + PW'(1);
            end
          end
          ST_DEAS: begin
            if (w_at_zero) begin
              w_state_next = ST_WAIT;
            end
          end
          default: begin
            w_state_next = ST_WAIT;
          end
        endcase
      end

      // Output decode: the pulse is high exactly while in SIG.
      always_comb begin
        w_pulse = (r_state == ST_SIG);
      end

      assign out = w_pulse ^ INVERT;
    end
  endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one clock and reset.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS     = 4,
  parameter int                  CNT_WIDTH    = 10,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  PULSE_LENGTH = 0,
  parameter logic [CHANNELS-1:0] INVERT_MASK  = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // One channel per input bit, each with its own polarity.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      debounce_channel #(
        .CNT_WIDTH    (CNT_WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .PULSE_LENGTH (PULSE_LENGTH),
        .INVERT       (INVERT_MASK[gi])
      ) u_channel (
        .clk  (clk),
        .rstn (rstn),
        .in   (in[gi]),
        .out  (out[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: a level-mode bank (channel 2 active-low) and a
// pulse-mode bank, checked against a queue of expected strobes and pulses.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] in_a = 4'b0100;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] in_b = 4'b0000;
  logic [3:0] out_b, rise_b, fall_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  ev_t    ev_q[$];
  pulse_t pulse_q[$];

  debounce_bank #(
    .CHANNELS(4), .CNT_WIDTH(4), .SYNC_STAGES(2),
    .PULSE_LENGTH(0), .INVERT_MASK(4'b0100)
  ) u_lvl (
    .clk(clk), .rstn(rstn), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a)
  );

  debounce_bank #(
    .CHANNELS(4), .CNT_WIDTH(4), .SYNC_STAGES(2),
    .PULSE_LENGTH(5), .INVERT_MASK(4'b0000)
  ) u_pls (
    .clk(clk), .rstn(rstn), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe code: instance*100 + channel*10 + 1 for rise, 2 for fall.
  task automatic push_ev(input int code, input int at);
    ev_t e;
    e.code = code;
    e.cyc  = at;
    ev_q.push_back(e);
  endtask

  task automatic push_pulse(input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    pulse_q.push_back(p);
  endtask

  task automatic match_ev(input int code);
    ev_t e;
    if (ev_q.size() == 0) begin
      check_eq("unexpected_strobe", code, 0);
    end else begin
      e = ev_q.pop_front();
      check_eq("strobe_id", code, e.code);
      check_eq("strobe_cycle", cyc, e.cyc);
      $display("strobe %0d at cycle %0d (expected %0d at %0d)", code, cyc, e.code, e.cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Strobe monitor: every strobe seen must be the next expected one.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) if (rise_a[c] === 1'b1) match_ev(100 + c * 10 + 1);
    for (int c = 0; c < 4; c++) if (fall_a[c] === 1'b1) match_ev(100 + c * 10 + 2);
    for (int c = 0; c < 4; c++) if (rise_b[c] === 1'b1) match_ev(200 + c * 10 + 1);
    for (int c = 0; c < 4; c++) if (fall_b[c] === 1'b1) match_ev(200 + c * 10 + 2);
  end

  // Pulse monitor on the pulse-mode channel 0: start cycle and length.
  logic   prev_b0 = 1'b0;
  pulse_t cur_pulse;
  always @(negedge clk) begin
    if (out_b[0] === 1'b1 && !prev_b0) begin
      if (pulse_q.size() == 0) begin
        check_eq("unexpected_pulse", cyc, 0);
        cur_pulse.start = cyc;
        cur_pulse.len   = 5;
      end else begin
        cur_pulse = pulse_q.pop_front();
        check_eq("pulse_start", cyc, cur_pulse.start);
      end
    end else if (out_b[0] !== 1'b1 && prev_b0) begin
      check_eq("pulse_len", cyc - cur_pulse.start, cur_pulse.len);
      $display("pulse at cycle %0d length %0d", cur_pulse.start, cyc - cur_pulse.start);
    end
    prev_b0 <= (out_b[0] === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("reset_out_a", int'(out_a), 4);
    check_eq("reset_out_b", int'(out_b), 0);
    check_eq("reset_strobes", int'({rise_a, fall_a, rise_b, fall_b}), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press and release on level channel 0.
    n = cyc; in_a[0] = 1'b1; push_ev(101, n + 18);
    wait_cyc(n + 17); check_eq("press_out_early", int'(out_a[0]), 0);
    wait_cyc(n + 18); check_eq("press_out", int'(out_a[0]), 1);
    wait_cyc(n + 40);
    n = cyc; in_a[0] = 1'b0; push_ev(102, n + 18);
    wait_cyc(n + 17); check_eq("release_out_early", int'(out_a[0]), 1);
    wait_cyc(n + 18); check_eq("release_out", int'(out_a[0]), 0);
    wait_cyc(n + 30);

    // Bounce on channel 1, then settle high: exactly one rise.
    for (int k = 0; k < 34; k++) begin
      in_a[1] = 1'b1; repeat (3) @(negedge clk);
      in_a[1] = 1'b0; repeat (3) @(negedge clk);
    end
    check_eq("bounce_out", int'(out_a[1]), 0);
    n = cyc; in_a[1] = 1'b1; push_ev(111, n + 18);
    wait_cyc(n + 30);

    // Active-low channel 2: pressed by driving low.
    n = cyc; in_a[2] = 1'b0; push_ev(121, n + 18);
    wait_cyc(n + 17); check_eq("inv_out_early", int'(out_a[2]), 1);
    wait_cyc(n + 18); check_eq("inv_out", int'(out_a[2]), 0);
    wait_cyc(n + 30);

    // Independence: channels 0 and 3 pressed 7 cycles apart.
    n = cyc; in_a[0] = 1'b1; push_ev(101, n + 18);
    repeat (7) @(negedge clk);
    m = cyc; in_a[3] = 1'b1; push_ev(131, m + 18);
    wait_cyc(m + 30);
    check_eq("indep_out_a", int'(out_a), 4'b1011);

    // Pulse mode: long hold gives one 5-cycle pulse.
    n = cyc; in_b[0] = 1'b1; push_ev(201, n + 18); push_pulse(n + 18, 5);
    wait_cyc(n + 500);
    n = cyc; in_b[0] = 1'b0; push_ev(202, n + 18);
    wait_cyc(n + 40);
    n = cyc; in_b[0] = 1'b1; push_ev(201, n + 18); push_pulse(n + 18, 5);
    wait_cyc(n + 50);
    // Partial release: cnt never reaches 0, so no strobe and no pulse.
    in_b[0] = 1'b0; repeat (5) @(negedge clk);
    in_b[0] = 1'b1; repeat (60) @(negedge clk);
    check_eq("partial_out_b", int'(out_b), 0);

    // Reset in the middle of a pulse.
    n = cyc; in_b[0] = 1'b0; push_ev(202, n + 18);
    wait_cyc(n + 40);
    n = cyc; in_b[0] = 1'b1; push_ev(201, n + 18); push_pulse(n + 18, 3);
    wait_cyc(n + 20);
    check_eq("mid_pulse_out_b", int'(out_b[0]), 1);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rst_out_a", int'(out_a), 4'b0100);
    check_eq("rst_out_b", int'(out_b), 0);
    check_eq("rst_strobes", int'({rise_a, fall_a, rise_b, fall_b}), 0);
    rstn = 1'b1;
    m = cyc;
    push_ev(101, m + 18); push_ev(111, m + 18); push_ev(121, m + 18);
    push_ev(131, m + 18); push_ev(201, m + 18); push_pulse(m + 18, 5);
    wait_cyc(m + 17);
    check_eq("post_rst_out_a_early", int'(out_a), 4'b0100);
    check_eq("post_rst_out_b_early", int'(out_b), 0);
    wait_cyc(m + 18);
    check_eq("post_rst_out_a", int'(out_a), 4'b1011);
    check_eq("post_rst_out_b", int'(out_b), 1);
    wait_cyc(m + 40);

    check_eq("events_left", ev_q.size(), 0);
    check_eq("pulses_left", pulse_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
